// File: rtl/sw_led_ctrl.sv
// Board I/O stage: dip-switch sync/debounce and LED pin drive.
// Single 100 MHz sys0 domain, synchronous active-low reset.
module sw_led_ctrl #(
   parameter int unsigned TICK_DIV       = 100000,
   parameter int unsigned DB_TICKS       = 8,
   parameter int unsigned HB_TICKS       = 500,
   parameter int unsigned STRETCH_TICKS  = 50,
   parameter bit          LED_ACTIVE_LOW = 1'b1
) (
   input  logic        sys0_clk,
   input  logic        sys0_rstn,
   input  logic [7:0]  usr_sw_i,
   input  logic        link_up_i,
   input  logic [3:0]  act_i,
   output logic [7:0]  sw_o,
   output logic        sw_chg_o,
   output logic [15:0] led
);

   localparam int unsigned DIV_W = $clog2(TICK_DIV);
   localparam int unsigned DB_W  = $clog2(DB_TICKS + 1);
   localparam int unsigned HB_W  = (HB_TICKS > 1) ? $clog2(HB_TICKS) : 1;
   localparam int unsigned ST_W  =
      (STRETCH_TICKS > 0) ? $clog2(STRETCH_TICKS + 1) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
   localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_TICKS - 1);
   localparam logic [HB_W-1:0]  HB_LAST  = HB_W'(HB_TICKS - 1);
   localparam logic [ST_W-1:0]  ST_LOAD  = ST_W'(STRETCH_TICKS);

   logic [7:0]            sync1_q, sync1_d;
   logic [7:0]            sync2_q, sync2_d;
   logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
   logic [7:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
   logic [7:0]            sw_q, sw_d;
   logic                  sw_chg_q, sw_chg_d;
   logic [HB_W-1:0]       hb_cnt_q, hb_cnt_d;
   logic                  hb_q, hb_d;
   logic [3:0][ST_W-1:0]  st_cnt_q, st_cnt_d;
   logic [15:0]           led_q, led_d;
   logic                  tick;
   logic [15:0]           lit;

   // Two-flop synchronizer and the free-running tick divider.
   always_comb begin
      sync1_d = usr_sw_i;
      sync2_d = sync1_q;
      tick    = (div_cnt_q == DIV_LAST);
      if (tick) begin
         div_cnt_d = '0;
      end else begin
         div_cnt_d = div_cnt_q + DIV_W'(1);
      end
   end

   // Per-bit debounce: count ticks of continuous disagreement.
   always_comb begin
      sw_d     = sw_q;
      db_cnt_d = db_cnt_q;
      for (int i = 0; i < 8; i++) begin
         if (sync2_q[i] == sw_q[i]) begin
            db_cnt_d[i] = '0;
         end else if (tick) begin
            if (db_cnt_q[i] == DB_LAST) begin
               sw_d[i]     = ~sw_q[i];
               db_cnt_d[i] = '0;
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
            end
         end
      end
      sw_chg_d = (sw_d != sw_q);
   end

   // Heartbeat half-period counter.
   always_comb begin
      hb_cnt_d = hb_cnt_q;
      hb_d     = hb_q;
      if (tick) begin
         if (hb_cnt_q == HB_LAST) begin
            hb_cnt_d = '0;
            hb_d     = ~hb_q;
         end else begin
            hb_cnt_d = hb_cnt_q + HB_W'(1);
         end
      end
   end

   // Activity stretchers: a strobe reloads, ticks drain.
   always_comb begin
      st_cnt_d = st_cnt_q;
      for (int k = 0; k < 4; k++) begin
         if (act_i[k]) begin
            st_cnt_d[k] = ST_LOAD;
         end else if (tick && (st_cnt_q[k] != '0)) begin
            st_cnt_d[k] = st_cnt_q[k] - ST_W'(1);
         end
      end
   end

   // LED map in lit polarity, then converted to pin polarity.
   always_comb begin
      lit        = '0;
      lit[7:0]   = sw_q;
      lit[8]     = hb_q;
      lit[9]     = link_up_i;
      for (int k = 0; k < 4; k++) begin
         lit[10+k] = (st_cnt_q[k] != '0);
      end
      led_d = lit ^ {16{LED_ACTIVE_LOW}};
   end

   // State registers with synchronous reset.
   always_ff @(posedge sys0_clk) begin
      if (!sys0_rstn) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         div_cnt_q <= '0;
         db_cnt_q  <= '0;
         sw_q      <= '0;
         sw_chg_q  <= 1'b0;
         hb_cnt_q  <= '0;
         hb_q      <= 1'b0;
         st_cnt_q  <= '0;
         led_q     <= {16{LED_ACTIVE_LOW}};
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         div_cnt_q <= div_cnt_d;
         db_cnt_q  <= db_cnt_d;
         sw_q      <= sw_d;
         sw_chg_q  <= sw_chg_d;
         hb_cnt_q  <= hb_cnt_d;
         hb_q      <= hb_d;
         st_cnt_q  <= st_cnt_d;
         led_q     <= led_d;
      end
   end

   assign sw_o     = sw_q;
   assign sw_chg_o = sw_chg_q;
   assign led      = led_q;

endmodule

// File: tb/tb_sw_led_ctrl.sv
// Bench for sw_led_ctrl: random and directed stimulus against
// a timeline model built from tick counts and run lengths.
module tb_sw_led_ctrl;

   localparam int TD = 4;
   localparam int DB = 3;
   localparam int HB = 5;
   localparam int ST = 2;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [7:0]  usr_sw = 8'h00;
   logic        link = 1'b0;
   logic [3:0]  act = 4'h0;
   logic [7:0]  sw_o;
   logic        sw_chg;
   logic [15:0] led;

   always #5 clk = ~clk;

   sw_led_ctrl #(
      .TICK_DIV       (TD),
      .DB_TICKS       (DB),
      .HB_TICKS       (HB),
      .STRETCH_TICKS  (ST),
      .LED_ACTIVE_LOW (1'b1)
   ) dut (
      .sys0_clk  (clk),
      .sys0_rstn (rstn),
      .usr_sw_i  (usr_sw),
      .link_up_i (link),
      .act_i     (act),
      .sw_o      (sw_o),
      .sw_chg_o  (sw_chg),
      .led       (led)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check_eq(input string tag,
                           input logic [15:0] got,
                           input logic [15:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t",
                    tag, got, exp, $time);
   endtask

   // Model: n = cycle index since reset release.
   int          n;
   logic [7:0]  s1, s2, m_sw;
   logic        m_chg;
   logic [15:0] m_led;
   int          run_start [8];
   int          last_act [4];

   // Number of ticks in cycles 0..c (tick when c%TD == TD-1).
   function automatic int ticks_upto(input int c);
      return (c + 1) / TD;
   endfunction

   function automatic logic hb_after(input int c);
      return ((ticks_upto(c) / HB) % 2) == 1;
   endfunction

   function automatic logic st_lit(input int k, input int c);
      if (last_act[k] < 0) return 1'b0;
      return (ticks_upto(c) - ticks_upto(last_act[k])) < ST;
   endfunction

   task automatic model_reset();
      n = 0; s1 = '0; s2 = '0; m_sw = '0; m_chg = 1'b0;
      m_led = 16'hFFFF;
      for (int i = 0; i < 8; i++) run_start[i] = -1;
      for (int k = 0; k < 4; k++) last_act[k] = -1;
   endtask

   task automatic step();
      logic [15:0] lit;
      logic [7:0]  nsw;
      bit          tk;
      @(posedge clk);
      if (!rstn) begin
         model_reset();
      end else begin
         lit = '0;
         lit[7:0] = m_sw;
         lit[8] = hb_after(n - 1);
         lit[9] = link;
         for (int k = 0; k < 4; k++) lit[10+k] = st_lit(k, n - 1);
         m_led = ~lit;
         tk = (n % TD) == TD - 1;
         nsw = m_sw;
         for (int i = 0; i < 8; i++) begin
            if (s2[i] == m_sw[i]) begin
               run_start[i] = -1;
            end else begin
               if (run_start[i] < 0) run_start[i] = n;
               if (tk && (ticks_upto(n) -
                          ticks_upto(run_start[i] - 1)) >= DB) begin
                  nsw[i] = ~m_sw[i];
                  run_start[i] = -1;
               end
            end
         end
         m_chg = (nsw != m_sw);
         m_sw = nsw;
         s2 = s1;
         s1 = usr_sw;
         for (int k = 0; k < 4; k++) if (act[k]) last_act[k] = n;
         n++;
      end
      #1;
      check_eq("sw_o", {8'h00, sw_o}, {8'h00, m_sw});
      check_eq("sw_chg_o", {15'h0, sw_chg}, {15'h0, m_chg});
      check_eq("led", led, m_led);
   endtask

   initial begin
      int pulses;
      int lat;
      int tg [3];
      int ntg;
      logic prev;
      logic [7:0] one;

      model_reset();

      // Reset held with switches and strobes active.
      rstn = 1'b0; usr_sw = 8'hFF; act = 4'hF;
      repeat (3) begin
         step();
         check_eq("rst_led", led, 16'hFFFF);
      end
      rstn = 1'b1; act = 4'h0;
      pulses = 0;
      for (int c = 0; c < 20; c++) begin
         step();
         if (sw_chg) pulses++;
      end
      check_eq("rel_chg_pulses", 16'(pulses), 16'd1);
      check_eq("rel_sw_ff", {8'h00, sw_o}, 16'h00FF);

      // Return to all-off, then a stable rise on bit 0.
      usr_sw = 8'h00;
      repeat (20) step();
      usr_sw = 8'h01;
      lat = 0;
      for (int c = 1; c <= 30 && lat == 0; c++) begin
         step();
         if (sw_o[0]) lat = c;
      end
      check_eq("deb_latency_range",
               16'((lat >= 11) && (lat <= 14)), 16'd1);
      step();
      check_eq("led0_lit", {15'h0, led[0]}, 16'h0);

      // Glitch on bit 1 shorter than the debounce window.
      usr_sw[1] = 1'b1;
      repeat (6) step();
      usr_sw[1] = 1'b0;
      pulses = 0;
      for (int c = 0; c < 20; c++) begin
         step();
         if (sw_chg) pulses++;
      end
      check_eq("glitch_no_chg", 16'(pulses), 16'd0);
      check_eq("glitch_sw1", {15'h0, sw_o[1]}, 16'h0);

      // Heartbeat toggle spacing from a fresh reset.
      rstn = 1'b0; step(); rstn = 1'b1;
      prev = led[8];
      ntg = 0;
      for (int c = 1; c <= 70; c++) begin
         step();
         if (led[8] != prev && ntg < 3) begin
            tg[ntg] = c;
            ntg++;
         end
         prev = led[8];
      end
      check_eq("hb_toggles", 16'(ntg), 16'd3);
      if (ntg == 3) begin
         check_eq("hb_first", 16'(tg[0]), 16'd21);
         check_eq("hb_period1", 16'(tg[1] - tg[0]), 16'd20);
         check_eq("hb_period2", 16'(tg[2] - tg[1]), 16'd20);
      end

      // Stretch: strobe coinciding with a tick, then retrigger.
      rstn = 1'b0; step(); rstn = 1'b1;
      repeat (3) step();
      act = 4'b0100; step(); act = 4'h0;
      step();
      check_eq("st_lit_2cyc", {15'h0, led[12]}, 16'h0);
      repeat (3) step();
      act = 4'b0100; step(); act = 4'h0;
      repeat (12) step();
      check_eq("st_off", {15'h0, led[12]}, 16'h1);

      // Reset in mid-debounce and mid-stretch.
      usr_sw = 8'h10;
      repeat (4) step();
      act = 4'b0001; step(); act = 4'h0;
      step();
      rstn = 1'b0; step();
      check_eq("midrst_led", led, 16'hFFFF);
      rstn = 1'b1;
      lat = 0;
      for (int c = 1; c <= 30 && lat == 0; c++) begin
         step();
         if (sw_o[4]) lat = c;
      end
      check_eq("midrst_full_deb",
               16'((lat >= 11) && (lat <= 14)), 16'd1);

      // Randomized traffic.
      for (int blk = 0; blk < 10; blk++) begin
         int rate;
         rate = (blk % 2 == 0) ? 60 : 8;
         for (int c = 0; c < 200; c++) begin
            if ($urandom_range(0, rate) == 0) begin
               one = 8'h01 << $urandom_range(0, 7);
               usr_sw = usr_sw ^ one;
            end
            act = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            if ($urandom_range(0, 31) == 0) link = ~link;
            rstn = ($urandom_range(0, 399) != 0);
            step();
         end
      end
      rstn = 1'b1; act = 4'h0;
      repeat (20) step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/sw_led_ctrl.md
Name: sw_led_ctrl

Overview:
- Board-I/O stage of the 4SGX230N platform, between the top-level pins and the application.
- Consumes the raw dip-switch bus (usr_sw) and synchronizes and debounces it into clean switch values for the core.
- Produces the 16-bit led pin bus from:
  - the debounced switch state,
  - a heartbeat,
  - a PCIe link-up status bit,
  - pulse-stretched activity indicators.
- Runs entirely in the 100 MHz sys0 domain.

Parameters:
- TICK_DIV, 100000: sys0_clk cycles per timebase tick (1 ms at 100 MHz); must be >= 2.
- DB_TICKS, 8: consecutive ticks a switch must differ from its debounced value before the change is accepted; must be >= 1.
- HB_TICKS, 500: ticks per heartbeat half-period.
- STRETCH_TICKS, 50: ticks an activity LED stays lit after its last pulse.
- LED_ACTIVE_LOW, 1: 1 means a lit LED drives 0 on the pin; 0 means a lit LED drives 1.

Ports:
- sys0_clk, input, 1: 100 MHz free-running clock; the only clock in the block.
- sys0_rstn, input, 1: reset; synchronous, active-low.
- usr_sw_i, input, 8: raw dip switches, asynchronous to sys0_clk.
- link_up_i, input, 1: PCIe link-up level, already in the sys0 domain.
- act_i, input, 4: single-cycle activity strobes, sys0 domain.
- sw_o, output, 8: debounced switch values.
- sw_chg_o, output, 1: one-cycle strobe, asserted in the first cycle sw_o shows a new value.
- led, output, 16: LED pin drive.

Behaviour:
- Reset (sys0_rstn low at a clock edge) clears every register on that edge, regardless of activity:
  - sw_o = 0, sw_chg_o = 0, all counters = 0, heartbeat = 0, stretch counters = 0.
  - All LEDs unlit, so led = 16'hFFFF when LED_ACTIVE_LOW = 1, or 16'h0000 otherwise.
  - A reset in mid-debounce discards any partial count.
- Synchronizer:
  - Two flops per bit on usr_sw_i, both reset to 0.
  - The debounce logic sees only the second flop (sw_s).
- Timebase:
  - div_cnt counts 0 .. TICK_DIV-1 and wraps to 0.
  - tick is a combinational one-cycle strobe, true when div_cnt == TICK_DIV-1.
  - The tick period is exactly TICK_DIV cycles.
- Debounce, independent per bit i:
  - If sw_s[i] == sw_o[i], db_cnt[i] is cleared to 0 every cycle. A glitch shorter than the required window therefore restarts the count.
  - If sw_s[i] != sw_o[i] and tick is true:
    - if db_cnt[i] == DB_TICKS-1, sw_o[i] toggles and db_cnt[i] is cleared;
    - otherwise db_cnt[i] increments.
  - db_cnt is ceil(log2(DB_TICKS+1)) bits wide and never exceeds DB_TICKS-1.
- Debounce latency, from a stable change at the pins to sw_o:
  - minimum 2 + (DB_TICKS-1)*TICK_DIV + 1 cycles;
  - maximum 2 + DB_TICKS*TICK_DIV cycles.
- sw_chg_o:
  - Registered; equals 1 in exactly the cycle(s) in which any sw_o bit holds a value different from the previous cycle.
  - Several bits flipping on the same tick produce a single one-cycle pulse.
  - After reset with switches already on, sw_o rises after debounce and sw_chg_o pulses. This is intended.
- Heartbeat:
  - hb_cnt increments on each tick.
  - On a tick with hb_cnt == HB_TICKS-1, hb_cnt clears to 0 and hb toggles.
  - Half-period is exactly HB_TICKS*TICK_DIV cycles.
- Activity stretch, per k in 0..3:
  - act_i[k] = 1 loads st_cnt[k] = STRETCH_TICKS.
  - Otherwise, on a tick with st_cnt[k] != 0, st_cnt[k] decrements.
  - If a load and a tick coincide, the load wins.
  - The LED is lit while st_cnt[k] != 0, so it lights the cycle after the strobe.
  - A retrigger extends the lit time; it never shortens it.
- LED map (lit-state, before polarity is applied):
  - [7:0] = sw_o
  - [8] = hb
  - [9] = link_up_i, registered once
  - [13:10] = st_cnt[3:0] != 0
  - [15:14] = 0 (unlit)
- The led output is registered and is XORed with {16{LED_ACTIVE_LOW}}. It lags its sources by one cycle.

Test Plan:
All scenarios use TICK_DIV=4, DB_TICKS=3, HB_TICKS=5, STRETCH_TICKS=2, LED_ACTIVE_LOW=1.
- Reset: hold sys0_rstn=0 for 3 cycles with usr_sw_i=8'hFF and act_i=4'hF -> led=16'hFFFF, sw_o=0, sw_chg_o=0 throughout; release -> sw_o=8'hFF within 2+12 cycles, with exactly one sw_chg_o pulse.
- Stable change: usr_sw_i[0] 0->1 and held -> sw_o[0]=1 between cycles 11 and 14 after the edge; single sw_chg_o pulse in that same cycle; led[0]=0 one cycle later.
- Glitch rejection: usr_sw_i[1]=1 for 6 cycles, then 0 -> sw_o[1] stays 0 and no sw_chg_o pulse.
- Heartbeat: after reset release, led[8] toggles every 20 cycles (first toggle at cycle 20 plus 1 register cycle), with exactly 20 cycles between toggles.
- Stretch: act_i[2] pulse for 1 cycle -> led[12]=0 starting 2 cycles later and lasting 5-8 cycles; a second pulse while lit reloads the count and extends the lit time; act_i pulse coinciding with a tick -> count reloads to 2, not 1.
- Reset mid-operation: assert reset 5 cycles into a debounce and 1 cycle into a stretch -> all outputs return to reset values on the next edge; after release, the debounce restarts from 0 and needs the full 3 ticks.
